amdf_frame_buffer: RTL and testbench

- Upstream feeder for the AMDF pitch stage.
- Accepts a stream of 16-bit PCM samples over a valid/ready handshake and keeps a sliding window of the N most recent samples.
- Each time a frame completes, it emits the window as a flattened N-sample frame, with overlapping frames advanced by HOP samples.
- The output frame register is held stable until the consumer acknowledges it, so the AMDF stage always sees a coherent frame.

---
 rtl/amdf_frame_buffer.sv | 83 ++++++++
 tb/tb_amdf_frame_buffer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/amdf_frame_buffer.sv
// Sliding N-sample window over a PCM stream; emits overlapping frames every HOP samples.
// Frame register holds until consumed; input stalls only when a completing sample would overwrite it.
module amdf_frame_buffer #(
  parameter int N   = 12,
  parameter int HOP = 6,
  parameter int W   = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           restart,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic [W-1:0]   s_data,
  output logic [W*N-1:0] frame,
  output logic           frame_valid,
  input  logic           frame_ready,
  output logic [15:0]    frame_count
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {PRIME, RUN} state_t;

  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic [W*N-1:0] r_window;
  logic [W*N-1:0] r_frame;
  logic           r_frame_valid;
  logic [15:0]    r_frame_count;

  logic           w_completes;
  logic           w_accept;
  logic           w_consume;
  logic [W*N-1:0] w_shifted;

  assign w_completes = ((r_state == PRIME) && (r_cnt == CW'(N - 1))) ||
                       ((r_state == RUN)   && (r_cnt == CW'(HOP - 1)));

  // Only a completing sample can be stalled; all others slide into the window freely.
  assign s_ready   = !reset && !(r_frame_valid && !frame_ready && w_completes);
  assign w_accept  = s_valid && s_ready && !restart;
  assign w_consume = r_frame_valid && frame_ready;
  assign w_shifted = {s_data, r_window[W*N-1:W]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= PRIME;
      r_cnt         <= '0;
      r_window      <= '0;
      r_frame       <= '0;
      r_frame_valid <= 1'b0;
      r_frame_count <= '0;
    end else if (restart) begin
      // Frame contents are deliberately kept; only its validity is dropped.
      r_state       <= PRIME;
      r_cnt         <= '0;
      r_window      <= '0;
      r_frame_valid <= 1'b0;
      r_frame_count <= '0;
    end else begin
      if (w_accept) begin
        r_window <= w_shifted;
        if (w_completes) begin
          r_frame       <= w_shifted;
          r_frame_count <= r_frame_count + 16'd1;
          r_cnt         <= '0;
          r_state       <= RUN;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
      if (w_accept && w_completes)
        r_frame_valid <= 1'b1;
      else if (w_consume)
        r_frame_valid <= 1'b0;
    end
  end

  assign frame       = r_frame;
  assign frame_valid = r_frame_valid;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_amdf_frame_buffer.sv
// Drives two buffers (HOP=6 and HOP=1) with shared stimulus and checks both against
// a model built from the accepted-sample history.
module tb_amdf_frame_buffer;

  localparam int N  = 12;
  localparam int W  = 16;
  localparam int FW = W * N;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          restart = 1'b0;
  logic          s_valid = 1'b0;
  logic [W-1:0]  s_data = '0;
  logic          frame_ready = 1'b0;

  logic          s_ready [2];
  logic [FW-1:0] frame [2];
  logic          frame_valid [2];
  logic [15:0]   frame_count [2];

  always #5 clk = ~clk;

  amdf_frame_buffer #(.N(N), .HOP(6), .W(W)) u_dut_hop6 (
    .clk(clk), .reset(reset), .restart(restart),
    .s_valid(s_valid), .s_ready(s_ready[0]), .s_data(s_data),
    .frame(frame[0]), .frame_valid(frame_valid[0]), .frame_ready(frame_ready),
    .frame_count(frame_count[0])
  );

  amdf_frame_buffer #(.N(N), .HOP(1), .W(W)) u_dut_hop1 (
    .clk(clk), .reset(reset), .restart(restart),
    .s_valid(s_valid), .s_ready(s_ready[1]), .s_data(s_data),
    .frame(frame[1]), .frame_valid(frame_valid[1]), .frame_ready(frame_ready),
    .frame_count(frame_count[1])
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Reference model: frames are the last N samples accepted since reset/restart,
  // produced when the accepted count reaches N, N+HOP, N+2*HOP, ...
  int            hop_k [2] = '{6, 1};
  int            m_acc [2];
  logic [W-1:0]  m_q [2][$];
  logic [FW-1:0] m_frame [2];
  logic          m_fv [2];
  int            m_fc [2];
  logic          m_took [2];

  function automatic logic completes_at(input int k, input int n);
    return (n >= N) && (((n - N) % hop_k[k]) == 0);
  endfunction

  function automatic logic exp_ready(input int k);
    return !reset && !(m_fv[k] && !frame_ready && completes_at(k, m_acc[k] + 1));
  endfunction

  function automatic logic [FW-1:0] last_n(input int k);
    logic [FW-1:0] f;
    int base;
    f = '0;
    base = m_q[k].size() - N;
    for (int i = 0; i < N; i++) f[i*W +: W] = m_q[k][base + i];
    return f;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_acc[k] = 0; m_q[k].delete(); m_frame[k] = '0; m_fv[k] = 1'b0; m_fc[k] = 0; m_took[k] = 1'b0;
    end
  endtask

  task automatic model_step(input logic v, input logic [W-1:0] d, input logic fr, input logic rs,
                            input logic rdy0, input logic rdy1);
    logic rdy [2];
    rdy[0] = rdy0; rdy[1] = rdy1;
    for (int k = 0; k < 2; k++) begin
      m_took[k] = 1'b0;
      if (rs) begin
        m_acc[k] = 0; m_q[k].delete(); m_fv[k] = 1'b0; m_fc[k] = 0;
      end else begin
        logic cons;
        cons = m_fv[k] && fr;
        if (v && rdy[k]) begin
          m_took[k] = 1'b1;
          m_q[k].push_back(d);
          if (m_q[k].size() > N) void'(m_q[k].pop_front());
          m_acc[k]++;
          if (completes_at(k, m_acc[k])) begin
            m_frame[k] = last_n(k);
            m_fv[k] = 1'b1;
            m_fc[k] = (m_fc[k] + 1) % 65536;
          end else if (cons) begin
            m_fv[k] = 1'b0;
          end
        end else if (cons) begin
          m_fv[k] = 1'b0;
        end
      end
    end
  endtask

  task automatic check_outputs();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("frame_valid[%0d]", k), FW'(frame_valid[k]), FW'(m_fv[k]));
      chk($sformatf("frame[%0d]", k), frame[k], m_frame[k]);
      chk($sformatf("frame_count[%0d]", k), FW'(frame_count[k]), FW'(m_fc[k][15:0]));
    end
  endtask

  // Called at a falling edge: drive, check ready, clock, update model, check outputs.
  task automatic cycle(input logic v, input logic [W-1:0] d, input logic fr, input logic rs);
    logic r0, r1;
    s_valid = v; s_data = d; frame_ready = fr; restart = rs;
    #1;
    r0 = exp_ready(0); r1 = exp_ready(1);
    chk("s_ready[0]", FW'(s_ready[0]), FW'(r0));
    chk("s_ready[1]", FW'(s_ready[1]), FW'(r1));
    @(posedge clk);
    model_step(v, d, fr, rs, r0, r1);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic random_phase(input int cycles, input int restart_odds);
    for (int c = 0; c < cycles; c++)
      cycle(($urandom_range(0, 3) != 0), W'($urandom), ($urandom_range(0, 2) != 0),
            ($urandom_range(0, restart_odds) == 0));
  endtask

  logic [W-1:0] v;

  initial begin
    model_reset();
    @(negedge clk);
    #1;
    chk("reset_s_ready0", FW'(s_ready[0]), FW'(0));
    chk("reset_s_ready1", FW'(s_ready[1]), FW'(0));
    check_outputs();
    @(negedge clk);
    reset = 1'b0;

    // Prime then two hops.
    for (int i = 1; i <= N; i++) cycle(1'b1, W'(i), 1'b1, 1'b0);
    chk("prime_fc", FW'(frame_count[0]), FW'(1));
    chk("prime_slot0", FW'(frame[0][0 +: W]), FW'(1));
    chk("prime_slot11", FW'(frame[0][11*W +: W]), FW'(12));
    for (int i = 13; i <= 24; i++) cycle(1'b1, W'(i), 1'b1, 1'b0);
    chk("hop_fc", FW'(frame_count[0]), FW'(3));
    chk("hop_slot0", FW'(frame[0][0 +: W]), FW'(13));
    chk("hop1_fc", FW'(frame_count[1]), FW'(13));

    // Backpressure: frame held with frame_ready low, then released for one cycle.
    cycle(1'b1, 16'd99, 1'b1, 1'b1);
    for (int i = 1; i <= N; i++) cycle(1'b1, W'(i), 1'b1, 1'b0);
    cycle(1'b0, 16'd0, 1'b0, 1'b0);
    v = 16'd13;
    for (int c = 0; c < 8; c++) begin
      cycle(1'b1, v, 1'b0, 1'b0);
      if (m_took[0]) v++;
    end
    chk("bp_stalled_at", FW'(v), FW'(18));
    chk("bp_frame_held", FW'(frame[0][0 +: W]), FW'(1));
    cycle(1'b1, v, 1'b1, 1'b0);
    chk("bp_slot0", FW'(frame[0][0 +: W]), FW'(7));
    chk("bp_slot11", FW'(frame[0][11*W +: W]), FW'(18));

    // Restart mid-prime, then a fresh prime.
    for (int i = 1; i <= 5; i++) cycle(1'b1, W'(i), 1'b1, 1'b0);
    cycle(1'b1, 16'd55, 1'b1, 1'b1);
    chk("restart_fc", FW'(frame_count[0]), FW'(0));
    for (int i = 100; i <= 111; i++) cycle(1'b1, W'(i), 1'b1, 1'b0);
    chk("reprime_slot0", FW'(frame[0][0 +: W]), FW'(100));
    chk("reprime_slot11", FW'(frame[0][11*W +: W]), FW'(111));

    random_phase(3000, 200);

    // Asynchronous reset in the middle of a cycle.
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("areset_s_ready0", FW'(s_ready[0]), FW'(0));
    chk("areset_s_ready1", FW'(s_ready[1]), FW'(0));
    check_outputs();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    reset = 1'b0;

    random_phase(3000, 400);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
